// File: rtl/ram1_pkg.sv
// Shared types and widths for the RAM1 arbiter: FSM state encoding, port id and
// the CPU/SRAM bus widths.
package ram1_pkg;

    localparam int RAM_AW = 18;
    localparam int RAM_DW = 16;
    localparam int CPU_AW = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_DONE
    } state_e;

    typedef enum logic {
        PORT_IF,
        PORT_DM
    } port_e;

endpackage

// File: rtl/ram1_arbiter.sv
// Two-port arbiter (instruction fetch, data memory) in front of a single
// asynchronous SRAM; data port wins ties, one access in flight at a time.
module ram1_arbiter
    import ram1_pkg::*;
#(
    parameter int READ_WAIT = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              IfReq,
    input  logic [CPU_AW-1:0] IfAddr,
    output logic [RAM_DW-1:0] IfData,
    output logic              IfAck,
    input  logic              DmRead,
    input  logic              DmWrite,
    input  logic [CPU_AW-1:0] DmAddr,
    input  logic [RAM_DW-1:0] DmWData,
    output logic [RAM_DW-1:0] DmRData,
    output logic              DmAck,
    output logic              IfStall,
    output logic              DmStall,
    output logic              Ram1_EN,
    output logic              Ram1_OE,
    output logic              Ram1_WE,
    output logic [RAM_AW-1:0] Ram1_address,
    inout  wire  [RAM_DW-1:0] Ram1_data
);

    state_e            state_q;
    port_e             port_q;
    logic [1:0]        wait_q;
    logic [CPU_AW-1:0] addr_q;
    logic [RAM_DW-1:0] wdata_q;
    logic [RAM_DW-1:0] if_data_q;
    logic [RAM_DW-1:0] dm_rdata_q;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic              en_q;
    logic              oe_q;
    logic              we_q;
    logic              drive_q;

    // NOTE: every register below is assigned with <= so all of them update from
    // the same pre-edge values; a blocking = here would chain same-cycle updates.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            port_q     <= PORT_IF;
            wait_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_data_q  <= '0;
            dm_rdata_q <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            en_q       <= 1'b1;
            oe_q       <= 1'b1;
            we_q       <= 1'b1;
            drive_q    <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (DmRead || DmWrite) begin
                        port_q  <= PORT_DM;
                        addr_q  <= DmAddr;
                        wdata_q <= DmWData;
                        en_q    <= 1'b0;
                        // A simultaneous read+write request is served as a write.
                        if (DmWrite) begin
                            state_q <= ST_WR_SETUP;
                            drive_q <= 1'b1;
                        end else begin
                            state_q <= ST_RD;
                            oe_q    <= 1'b0;
                            wait_q  <= 2'(READ_WAIT);
                        end
                    end else if (IfReq) begin
                        port_q  <= PORT_IF;
                        addr_q  <= IfAddr;
                        en_q    <= 1'b0;
                        oe_q    <= 1'b0;
                        wait_q  <= 2'(READ_WAIT);
                        state_q <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (wait_q == 2'd0) begin
                        if (port_q == PORT_DM) begin
                            dm_rdata_q <= Ram1_data;
                            dm_ack_q   <= 1'b1;
                        end else begin
                            if_data_q <= Ram1_data;
                            if_ack_q  <= 1'b1;
                        end
                        en_q    <= 1'b1;
                        oe_q    <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        wait_q <= wait_q - 2'd1;
                    end
                end
                ST_WR_SETUP: begin
                    we_q    <= 1'b0;
                    state_q <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    we_q    <= 1'b1;
                    state_q <= ST_WR_HOLD;
                end
                ST_WR_HOLD: begin
                    drive_q  <= 1'b0;
                    en_q     <= 1'b1;
                    dm_ack_q <= 1'b1;
                    state_q  <= ST_DONE;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Drive enable only spans the write states, in which OE is held high.
    assign Ram1_data    = drive_q ? wdata_q : {RAM_DW{1'bz}};
    assign Ram1_address = {2'b00, addr_q};
    assign Ram1_EN      = en_q;
    assign Ram1_OE      = oe_q;
    assign Ram1_WE      = we_q;
    assign IfData       = if_data_q;
    assign DmRData      = dm_rdata_q;
    assign IfAck        = if_ack_q;
    assign DmAck        = dm_ack_q;
    assign IfStall      = IfReq & ~if_ack_q;
    assign DmStall      = (DmRead | DmWrite) & ~dm_ack_q;

endmodule

// File: tb/tb_ram1_arbiter.sv
// Directed bench for ram1_arbiter: three instances (READ_WAIT 0/1/3) share stimulus,
// each with an SRAM model on its bus; instance READ_WAIT=1 is checked in detail.
module tb_ram1_arbiter;

    logic        Clk;
    logic        Rst;
    logic        IfReq;
    logic [15:0] IfAddr;
    logic        DmRead;
    logic        DmWrite;
    logic [15:0] DmAddr;
    logic [15:0] DmWData;

    logic [15:0] if_data0, if_data1, if_data3;
    logic [15:0] dm_rdata0, dm_rdata1, dm_rdata3;
    logic        if_ack0, if_ack1, if_ack3;
    logic        dm_ack0, dm_ack1, dm_ack3;
    logic        if_stall0, if_stall1, if_stall3;
    logic        dm_stall0, dm_stall1, dm_stall3;
    logic        en0, en1, en3;
    logic        oe0, oe1, oe3;
    logic        we0, we1, we3;
    logic [17:0] addr0, addr1, addr3;
    wire  [15:0] bus0, bus1, bus3;

    logic [15:0] mem [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [15:0] pre_data;

    int n_checks;
    int n_errors;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    ram1_arbiter #(.READ_WAIT(0)) u_dut0 (
        .Clk(Clk), .Rst(Rst), .IfReq(IfReq), .IfAddr(IfAddr), .IfData(if_data0), .IfAck(if_ack0),
        .DmRead(DmRead), .DmWrite(DmWrite), .DmAddr(DmAddr), .DmWData(DmWData),
        .DmRData(dm_rdata0), .DmAck(dm_ack0), .IfStall(if_stall0), .DmStall(dm_stall0),
        .Ram1_EN(en0), .Ram1_OE(oe0), .Ram1_WE(we0), .Ram1_address(addr0), .Ram1_data(bus0)
    );

    ram1_arbiter #(.READ_WAIT(1)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .IfReq(IfReq), .IfAddr(IfAddr), .IfData(if_data1), .IfAck(if_ack1),
        .DmRead(DmRead), .DmWrite(DmWrite), .DmAddr(DmAddr), .DmWData(DmWData),
        .DmRData(dm_rdata1), .DmAck(dm_ack1), .IfStall(if_stall1), .DmStall(dm_stall1),
        .Ram1_EN(en1), .Ram1_OE(oe1), .Ram1_WE(we1), .Ram1_address(addr1), .Ram1_data(bus1)
    );

    ram1_arbiter #(.READ_WAIT(3)) u_dut3 (
        .Clk(Clk), .Rst(Rst), .IfReq(IfReq), .IfAddr(IfAddr), .IfData(if_data3), .IfAck(if_ack3),
        .DmRead(DmRead), .DmWrite(DmWrite), .DmAddr(DmAddr), .DmWData(DmWData),
        .DmRData(dm_rdata3), .DmAck(dm_ack3), .IfStall(if_stall3), .DmStall(dm_stall3),
        .Ram1_EN(en3), .Ram1_OE(oe3), .Ram1_WE(we3), .Ram1_address(addr3), .Ram1_data(bus3)
    );

    // SRAM models: drive read data while selected for read; undriven bus pulls to all-ones.
    pullup (bus0);
    pullup (bus1);
    pullup (bus3);
    assign bus0 = (!en0 && !oe0 && we0) ? mem[addr0[15:0]] : 16'hzzzz;
    assign bus1 = (!en1 && !oe1 && we1) ? mem[addr1[15:0]] : 16'hzzzz;
    assign bus3 = (!en3 && !oe3 && we3) ? mem[addr3[15:0]] : 16'hzzzz;

    // Only the READ_WAIT=1 instance is allowed to write the shared array.
    always @(posedge Clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (!en1 && !we1)
            mem[addr1[15:0]] <= bus1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Per-cycle traces of instance 1 (bit c = cycle c after request presentation).
    logic [15:0] oe_m, we_m, en_m, drv_m, if_ack_m, dm_ack_m, if_stall_m, dm_stall_m;
    logic [17:0] addr_mid;
    logic [15:0] if_seen, dm_seen, if_seen0, if_seen3;
    int          first_ack0, first_ack3;

    task automatic run(input int n, input int rst_cycle);
        logic rel_if, rel_dm;
        oe_m = '0; we_m = '0; en_m = '0; drv_m = '0;
        if_ack_m = '0; dm_ack_m = '0; if_stall_m = '0; dm_stall_m = '0;
        addr_mid = '0; first_ack0 = -1; first_ack3 = -1;
        for (int c = 0; c < n; c++) begin
            if (c == rst_cycle) begin
                Rst = 1'b1; IfReq = 1'b0; DmRead = 1'b0; DmWrite = 1'b0;
            end
            if (c == rst_cycle + 1) Rst = 1'b0;
            @(negedge Clk);
            oe_m[c]       = !oe1;
            we_m[c]       = !we1;
            en_m[c]       = !en1;
            drv_m[c]      = oe1 && (bus1 !== 16'hFFFF);
            if_ack_m[c]   = if_ack1;
            dm_ack_m[c]   = dm_ack1;
            if_stall_m[c] = if_stall1;
            dm_stall_m[c] = dm_stall1;
            if (c == 2) addr_mid = addr1;
            if (if_ack1) if_seen = if_data1;
            if (dm_ack1) dm_seen = dm_rdata1;
            if (if_ack0 && first_ack0 < 0) begin first_ack0 = c; if_seen0 = if_data0; end
            if (if_ack3 && first_ack3 < 0) begin first_ack3 = c; if_seen3 = if_data3; end
            rel_if = if_ack1;
            rel_dm = dm_ack1;
            @(posedge Clk);
            #1;
            if (rel_if) IfReq = 1'b0;
            if (rel_dm) begin DmRead = 1'b0; DmWrite = 1'b0; end
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1; IfReq = 1'b0; DmRead = 1'b0; DmWrite = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge Clk);
        check({tag, "_en_oe_we"}, {29'd0, en1, oe1, we1}, 32'd7);
        check({tag, "_acks"}, {30'd0, if_ack1, dm_ack1}, 32'd0);
        check({tag, "_ifdata"}, {16'd0, if_data1}, 32'd0);
        check({tag, "_dmrdata"}, {16'd0, dm_rdata1}, 32'd0);
        check({tag, "_addr"}, {14'd0, addr1}, 32'd0);
        check({tag, "_bus_z"}, {16'd0, bus1}, 32'h0000FFFF);
        @(posedge Clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        @(posedge Clk);
        #1 pre_we = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        Rst = 1'b1; IfReq = 1'b0; DmRead = 1'b0; DmWrite = 1'b0;
        IfAddr = '0; DmAddr = '0; DmWData = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        if_seen = '0; dm_seen = '0; if_seen0 = '0; if_seen3 = '0;
        #1;
        preload(16'h0010, 16'hBEEF);
        preload(16'h1234, 16'h0000);
        preload(16'h0020, 16'h0000);
        preload(16'h0030, 16'h0000);
        do_reset();
        check_reset_state("rst0");

        // Fetch read of 0x0010.
        IfAddr = 16'h0010; IfReq = 1'b1;
        run(6, -1);
        check("rd_oe_low", {16'd0, oe_m}, 32'b000110);
        check("rd_en_low", {16'd0, en_m}, 32'b000110);
        check("rd_we_low", {16'd0, we_m}, 32'b0);
        check("rd_if_ack", {16'd0, if_ack_m}, 32'b001000);
        check("rd_if_stall", {16'd0, if_stall_m}, 32'b000111);
        check("rd_addr", {14'd0, addr_mid}, 32'h00010);
        check("rd_if_data", {16'd0, if_seen}, 32'h0000BEEF);

        // Data write 0xA5A5 to 0x1234.
        DmAddr = 16'h1234; DmWData = 16'hA5A5; DmWrite = 1'b1;
        run(6, -1);
        check("wr_we_low", {16'd0, we_m}, 32'b000100);
        check("wr_bus_drv", {16'd0, drv_m}, 32'b001110);
        check("wr_oe_low", {16'd0, oe_m}, 32'b0);
        check("wr_dm_ack", {16'd0, dm_ack_m}, 32'b010000);
        check("wr_dm_stall", {16'd0, dm_stall_m}, 32'b001111);
        check("wr_mem", {16'd0, mem[16'h1234]}, 32'h0000A5A5);
        check("wr_ifdata_held", {16'd0, if_data1}, 32'h0000BEEF);
        check("wr_dmrdata_kept", {16'd0, dm_rdata1}, 32'd0);

        // Readback through the data port.
        DmAddr = 16'h1234; DmRead = 1'b1;
        run(5, -1);
        check("rb_dm_ack", {16'd0, dm_ack_m}, 32'b01000);
        check("rb_dm_data", {16'd0, dm_seen}, 32'h0000A5A5);
        check("rb_ifdata_held", {16'd0, if_data1}, 32'h0000BEEF);

        do_reset();
        check_reset_state("rst1");

        // Simultaneous fetch and data read: data port first.
        IfAddr = 16'h0010; IfReq = 1'b1; DmAddr = 16'h1234; DmRead = 1'b1;
        if_seen = '0; dm_seen = '0;
        run(9, -1);
        check("sim_dm_ack", {16'd0, dm_ack_m}, 32'b000001000);
        check("sim_if_ack", {16'd0, if_ack_m}, 32'b010000000);
        check("sim_if_stall", {16'd0, if_stall_m}, 32'b001111111);
        check("sim_dm_data", {16'd0, dm_seen}, 32'h0000A5A5);
        check("sim_if_data", {16'd0, if_seen}, 32'h0000BEEF);

        // Read and write together: behaves as a write.
        DmAddr = 16'h0020; DmWData = 16'h1357; DmRead = 1'b1; DmWrite = 1'b1;
        run(6, -1);
        check("rw_oe_low", {16'd0, oe_m}, 32'b0);
        check("rw_we_low", {16'd0, we_m}, 32'b000100);
        check("rw_dm_ack", {16'd0, dm_ack_m}, 32'b010000);
        check("rw_mem", {16'd0, mem[16'h0020]}, 32'h00001357);
        check("rw_dmrdata_kept", {16'd0, dm_rdata1}, 32'h0000A5A5);

        // Reset during WR_PULSE aborts the write.
        DmAddr = 16'h0030; DmWData = 16'h2468; DmWrite = 1'b1;
        run(7, 2);
        check("ab_we_low", {16'd0, we_m}, 32'b0000100);
        check("ab_en_low", {16'd0, en_m}, 32'b0000110);
        check("ab_bus_drv", {16'd0, drv_m}, 32'b0000110);
        check("ab_dm_ack", {16'd0, dm_ack_m}, 32'b0);
        check("ab_dmrdata", {16'd0, dm_rdata1}, 32'd0);

        // Read latency for READ_WAIT = 0, 1, 3.
        do_reset();
        IfAddr = 16'h0010; IfReq = 1'b1;
        run(8, -1);
        check("lat_rw0", first_ack0, 32'd2);
        check("lat_rw1", {16'd0, if_ack_m}, 32'b00001000);
        check("lat_rw3", first_ack3, 32'd5);
        check("lat_rw0_data", {16'd0, if_seen0}, 32'h0000BEEF);
        check("lat_rw3_data", {16'd0, if_seen3}, 32'h0000BEEF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram1_arbiter.md
RAM1_ARBITER -- requirements
Module: ram1_arbiter

Interface
REQ-001 Parameter READ_WAIT, default 1: extra RD cycles beyond the first; legal range 0..3.
REQ-002 Clk  in  1  system clock; all state changes on rising edge.
REQ-003 Rst  in  1  one clock; reset is synchronous and active-high.
REQ-004 IfReq  in  1  instruction-fetch read request; level, held until IfAck.
REQ-005 IfAddr  in  16  fetch word address.
REQ-006 IfData  out  16  fetch read data; valid while IfAck=1, held until next capture.
REQ-007 IfAck  out  1  one-cycle fetch completion pulse.
REQ-008 DmRead  in  1  data read request; level, held until DmAck.
REQ-009 DmWrite  in  1  data write request; level, held until DmAck.
REQ-010 DmAddr  in  16  data word address.
REQ-011 DmWData  in  16  write data.
REQ-012 DmRData  out  16  data read result; valid while DmAck=1, held until next capture.
REQ-013 DmAck  out  1  one-cycle data completion pulse.
REQ-014 IfStall, DmStall  out  1 each  per-port stall to pipeline.
REQ-015 Ram1_EN, Ram1_OE, Ram1_WE  out  1 each  SRAM chip/read/write enables, active-low.
REQ-016 Ram1_address  out  18  SRAM address; Ram1_data  inout  16  SRAM data bus.

Function
REQ-017 States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE; one access in flight at a time.
REQ-018 IDLE: DmRead|DmWrite pending -> grant Dm, else IfReq -> grant If, else stay IDLE.
REQ-019 DmRead and DmWrite both high: treated as write.
REQ-020 At grant: address, write data, port id, and read/write flag registered; Ram1_address = {2'b00, addr} and stable through DONE.
REQ-021 Read: IDLE -> RD for READ_WAIT+1 cycles (EN=0, OE=0, WE=1) -> DONE; Ram1_data captured into granted port's data register on last RD edge.
REQ-022 Write: IDLE -> WR_SETUP (EN=0, OE=1, WE=1) -> WR_PULSE (WE=0) -> WR_HOLD (WE=1) -> DONE; one cycle each.
REQ-023 Ram1_data driven with registered write data only in WR_SETUP, WR_PULSE, WR_HOLD; high-Z otherwise; OE=0 never coincides with drive.
REQ-024 DONE: granted port's Ack=1 for exactly one cycle, EN=OE=WE=1, next state IDLE; no grant evaluated in DONE.
REQ-025 Latency, request visible in cycle 0: read Ack in cycle READ_WAIT+2; write Ack in cycle 4.
REQ-026 Back-to-back: new grant evaluated in IDLE cycle after DONE; a port holding its request after Ack is served again.
REQ-027 IfStall = IfReq & ~IfAck; DmStall = (DmRead|DmWrite) & ~DmAck; combinational.
REQ-028 Request deasserted mid-access: access completes unchanged; Ack still pulses.
REQ-029 Request/address changes after grant ignored until next IDLE.
REQ-030 IfData/DmRData updated only on own port's read capture; writes never modify them.

Reset
REQ-031 Rst=1 at edge: state IDLE; Ram1_EN=Ram1_OE=Ram1_WE=1; Ram1_data high-Z; IfAck=DmAck=0; IfData=DmRData=0; Ram1_address=0.
REQ-032 Rst mid-access aborts immediately: no Ack for aborted access, no further WE pulse; write in WR_PULSE may be partial.

Structure
REQ-033 Shared package ram1_pkg: state enum, RAM_AW=18, RAM_DW=16, CPU_AW=16.
REQ-034 Single FSM module; no sub-module natural; tri-state bus drive confined to one continuous assignment.

Verification
REQ-035 READ_WAIT=1, preload mem[0x0010]=0xBEEF, IfReq addr 0x0010 -> OE low cycles 1-2, IfAck cycle 3, IfData=0xBEEF, IfStall high cycles 0-2.
REQ-036 DmWrite addr 0x1234 data 0xA5A5 -> WE low only in cycle 2, bus driven cycles 1-3, DmAck cycle 4, readback 0xA5A5.
REQ-037 IfReq and DmRead same cycle -> Dm served first, DmAck cycle 3, IfAck cycle 7, IfStall high throughout.
REQ-038 DmRead+DmWrite both high -> write performed, no OE low.
REQ-039 Rst asserted in WR_PULSE -> next cycle IDLE, WE/EN high, bus Z, no DmAck.
REQ-040 READ_WAIT=0 and 3 -> read Ack cycles 2 and 5 respectively.
